// File: rtl/csr_trap_sequencer_if.sv
// Shared-port bundle between the trap unit / CSR-instruction path and the
// trap-entry sequencer. The slave modport is the sequencer's view.
interface csr_trap_sequencer_if #(
    parameter int XLEN = 64
);
    logic            TrapValid;
    logic            TrapReady;
    logic            TrapToM;
    logic [5:0]      TrapCause;
    logic [XLEN-1:0] TrapEPC;
    logic [XLEN-1:0] TrapTval;
    logic [1:0]      PrivilegeModeW;
    logic [XLEN-1:0] STATUS_REGW;
    logic [XLEN-1:0] MTVEC_REGW;
    logic [XLEN-1:0] STVEC_REGW;
    logic            CSRReqValid;
    logic            CSRReqReady;
    logic [11:0]     CSRReqAdr;
    logic [XLEN-1:0] CSRReqData;
    logic            CSRWrEn;
    logic [11:0]     CSRWrAdr;
    logic [XLEN-1:0] CSRWrData;
    logic            RedirectValid;
    logic [XLEN-1:0] RedirectPC;
    logic            BusyStall;

    modport master (
        output TrapValid, TrapToM, TrapCause, TrapEPC, TrapTval, PrivilegeModeW,
        output STATUS_REGW, MTVEC_REGW, STVEC_REGW,
        output CSRReqValid, CSRReqAdr, CSRReqData,
        input  TrapReady, CSRReqReady, CSRWrEn, CSRWrAdr, CSRWrData,
        input  RedirectValid, RedirectPC, BusyStall
    );

    modport slave (
        input  TrapValid, TrapToM, TrapCause, TrapEPC, TrapTval, PrivilegeModeW,
        input  STATUS_REGW, MTVEC_REGW, STVEC_REGW,
        input  CSRReqValid, CSRReqAdr, CSRReqData,
        output TrapReady, CSRReqReady, CSRWrEn, CSRWrAdr, CSRWrData,
        output RedirectValid, RedirectPC, BusyStall
    );
endinterface

// File: rtl/csr_trap_sequencer.sv
// Trap-entry sequencer: arbitrates the single CSR write port between trap
// entry (always wins) and CSR-instruction writes, then issues xEPC, xCAUSE,
// xTVAL, xSTATUS writes followed by a one-cycle fetch redirect.
// Optional build macro CSR_TRAP_VECTORED_EN enables vectored interrupt targets.
module csr_trap_sequencer #(
    parameter int XLEN = 64
) (
    input logic                clk,
    input logic                reset,
    csr_trap_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        W_EPC,
        W_CAUSE,
        W_TVAL,
        W_STATUS,
        REDIRECT
    } state_t;

    state_t state;

    // Trap context captured at acceptance
    logic              to_m_q;
    logic [5:0]        cause_q;
    logic [XLEN-1:0]   tval_q;
    logic [1:0]        priv_q;
    logic [XLEN-1:0]   status_q;
    logic [XLEN-1:2]   tvec_base_q;
`ifdef CSR_TRAP_VECTORED_EN
    logic              vectored_q;
`endif

    // Registered sequence outputs
    logic              wr_en_q;
    logic [11:0]       wr_adr_q;
    logic [XLEN-1:0]   wr_data_q;
    logic              redirect_q;
    logic [XLEN-1:0]   redirect_pc_q;

    logic              idle;
    logic              pass;
    logic [XLEN-1:0]   sel_tvec;
    logic [XLEN-1:0]   cause_word;
    logic [XLEN-1:0]   status_word;
    logic [XLEN-1:0]   target_pc;

    // Handshakes and the zero-latency CSR-instruction pass-through
    always_comb begin
        idle = (state == IDLE);
        pass = idle & ~reset & bus.CSRReqValid & ~bus.TrapValid;
        sel_tvec = bus.TrapToM ? bus.MTVEC_REGW : bus.STVEC_REGW;
    end

    assign bus.TrapReady     = idle & ~reset & bus.TrapValid;
    assign bus.CSRReqReady   = pass;
    assign bus.CSRWrEn       = wr_en_q | pass;
    assign bus.CSRWrAdr      = pass ? bus.CSRReqAdr  : wr_adr_q;
    assign bus.CSRWrData     = pass ? bus.CSRReqData : wr_data_q;
    assign bus.RedirectValid = redirect_q;
    assign bus.RedirectPC    = redirect_pc_q;
    assign bus.BusyStall     = ~idle;

    // Write data for xCAUSE / xSTATUS and the redirect target, from latched context
    always_comb begin
        cause_word  = {cause_q[5], {(XLEN-6){1'b0}}, cause_q[4:0]};
        status_word = status_q;
        if (to_m_q) begin
            status_word[7]     = status_q[3];
            status_word[3]     = 1'b0;
            status_word[12:11] = priv_q;
        end else begin
            status_word[5] = status_q[1];
            status_word[1] = 1'b0;
            status_word[8] = priv_q[0];
        end
        target_pc = {tvec_base_q, 2'b00};
`ifdef CSR_TRAP_VECTORED_EN
        if (vectored_q) begin
            target_pc = {tvec_base_q, 2'b00} + {{(XLEN-7){1'b0}}, cause_q[4:0], 2'b00};
        end
`endif
    end

    // Sequencer FSM; each write state presents values loaded on the preceding edge
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            to_m_q        <= 1'b0;
            cause_q       <= '0;
            tval_q        <= '0;
            priv_q        <= '0;
            status_q      <= '0;
            tvec_base_q   <= '0;
`ifdef CSR_TRAP_VECTORED_EN
            vectored_q    <= 1'b0;
`endif
            wr_en_q       <= 1'b0;
            wr_adr_q      <= '0;
            wr_data_q     <= '0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.TrapValid) begin
                        state       <= W_EPC;
                        to_m_q      <= bus.TrapToM;
                        cause_q     <= bus.TrapCause;
                        tval_q      <= bus.TrapTval;
                        priv_q      <= bus.PrivilegeModeW;
                        status_q    <= bus.STATUS_REGW;
                        tvec_base_q <= sel_tvec[XLEN-1:2];
`ifdef CSR_TRAP_VECTORED_EN
                        vectored_q  <= (sel_tvec[1:0] == 2'b01) & bus.TrapCause[5];
`endif
                        // EPC goes straight from the input into the first write
                        wr_en_q     <= 1'b1;
                        wr_adr_q    <= bus.TrapToM ? 12'h341 : 12'h141;
                        wr_data_q   <= {bus.TrapEPC[XLEN-1:1], 1'b0};
                    end
                end
                W_EPC: begin
                    state     <= W_CAUSE;
                    wr_adr_q  <= to_m_q ? 12'h342 : 12'h142;
                    wr_data_q <= cause_word;
                end
                W_CAUSE: begin
                    state     <= W_TVAL;
                    wr_adr_q  <= to_m_q ? 12'h343 : 12'h143;
                    wr_data_q <= tval_q;
                end
                W_TVAL: begin
                    state     <= W_STATUS;
                    wr_adr_q  <= to_m_q ? 12'h300 : 12'h100;
                    wr_data_q <= status_word;
                end
                W_STATUS: begin
                    state         <= REDIRECT;
                    wr_en_q       <= 1'b0;
                    wr_adr_q      <= '0;
                    wr_data_q     <= '0;
                    redirect_q    <= 1'b1;
                    redirect_pc_q <= target_pc;
                end
                REDIRECT: begin
                    state         <= IDLE;
                    redirect_q    <= 1'b0;
                    redirect_pc_q <= '0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_csr_trap_sequencer.sv
// Self-checking bench for csr_trap_sequencer. Expected CSR writes are queued
// as stimulus is driven; a negedge monitor pops and compares each write.
module tb_csr_trap_sequencer;

    localparam int XLEN = 64;

    typedef struct {
        logic [11:0]     adr;
        logic [XLEN-1:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;
    wr_t  exp_q[$];

    always #5 clk = ~clk;

    csr_trap_sequencer_if #(.XLEN(XLEN)) bus ();

    csr_trap_sequencer #(.XLEN(XLEN)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Scoreboard monitor: every write on the shared port must match the queue head
    always @(negedge clk) begin
        wr_t e;
        if (bus.CSRWrEn === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_write got adr=%h data=%h want no write", bus.CSRWrAdr, bus.CSRWrData);
            end else begin
                e = exp_q.pop_front();
                if (bus.CSRWrAdr !== e.adr || bus.CSRWrData !== e.data) begin
                    bad++;
                    $display("FAIL csr_write got adr=%h data=%h want adr=%h data=%h",
                             bus.CSRWrAdr, bus.CSRWrData, e.adr, e.data);
                end
            end
        end
    end

    task automatic idle_inputs();
        bus.TrapValid      = 1'b0;
        bus.TrapToM        = 1'b0;
        bus.TrapCause      = '0;
        bus.TrapEPC        = '0;
        bus.TrapTval       = '0;
        bus.PrivilegeModeW = '0;
        bus.STATUS_REGW    = '0;
        bus.MTVEC_REGW     = '0;
        bus.STVEC_REGW     = '0;
        bus.CSRReqValid    = 1'b0;
        bus.CSRReqAdr      = '0;
        bus.CSRReqData     = '0;
    endtask

    task automatic drive_trap(input logic to_m, input logic [5:0] cause, input logic [XLEN-1:0] epc,
                              input logic [XLEN-1:0] tval, input logic [1:0] priv,
                              input logic [XLEN-1:0] status, input logic [XLEN-1:0] mtvec,
                              input logic [XLEN-1:0] stvec);
        bus.TrapValid      = 1'b1;
        bus.TrapToM        = to_m;
        bus.TrapCause      = cause;
        bus.TrapEPC        = epc;
        bus.TrapTval       = tval;
        bus.PrivilegeModeW = priv;
        bus.STATUS_REGW    = status;
        bus.MTVEC_REGW     = mtvec;
        bus.STVEC_REGW     = stvec;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if ({bus.CSRWrEn, bus.TrapReady, bus.CSRReqReady, bus.RedirectValid, bus.BusyStall,
             bus.CSRWrAdr, bus.CSRWrData, bus.RedirectPC} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got en=%b tr=%b cr=%b rv=%b busy=%b adr=%h data=%h pc=%h want all 0",
                     bus.CSRWrEn, bus.TrapReady, bus.CSRReqReady, bus.RedirectValid, bus.BusyStall,
                     bus.CSRWrAdr, bus.CSRWrData, bus.RedirectPC);
        end
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_m_trap();
        @(posedge clk); #1;
        drive_trap(1'b1, 6'h02, 64'h8000_0103, 64'hDEAD, 2'b00, 64'h8, 64'h8000_0100, 64'h0);
        exp_q.push_back('{adr: 12'h341, data: 64'h8000_0102});
        exp_q.push_back('{adr: 12'h342, data: 64'h2});
        exp_q.push_back('{adr: 12'h343, data: 64'hDEAD});
        exp_q.push_back('{adr: 12'h300, data: 64'h80});
        @(negedge clk);
        total++;
        if ({bus.TrapReady, bus.CSRWrEn, bus.BusyStall} !== 3'b100) begin
            bad++;
            $display("FAIL m_cycle0 got ready/en/busy=%b%b%b want 100", bus.TrapReady, bus.CSRWrEn, bus.BusyStall);
        end
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk); #1;
            if (k == 1) bus.TrapValid = 1'b0;
            @(negedge clk);
            total++;
            if (bus.BusyStall !== (k <= 5) || bus.RedirectValid !== (k == 5) ||
                bus.CSRWrEn !== (k <= 4) || bus.TrapReady !== 1'b0) begin
                bad++;
                $display("FAIL m_timing cycle=%0d got busy=%b rv=%b en=%b tr=%b want busy=%b rv=%b en=%b tr=0",
                         k, bus.BusyStall, bus.RedirectValid, bus.CSRWrEn, bus.TrapReady,
                         (k <= 5), (k == 5), (k <= 4));
            end
            if (k == 5) begin
                total++;
                if (bus.RedirectPC !== 64'h8000_0100) begin
                    bad++;
                    $display("FAIL m_redirect_pc got %h want %h", bus.RedirectPC, 64'h8000_0100);
                end
            end
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL m_writes_pending got %0d want 0", exp_q.size());
        end
    endtask

    task automatic test_s_interrupt();
        logic [XLEN-1:0] want_pc;
`ifdef CSR_TRAP_VECTORED_EN
        want_pc = 64'h1014;
`else
        want_pc = 64'h1000;
`endif
        @(posedge clk); #1;
        drive_trap(1'b0, 6'h25, 64'h4000, 64'h0, 2'b00, 64'h2, 64'h9000, 64'h1001);
        exp_q.push_back('{adr: 12'h141, data: 64'h4000});
        exp_q.push_back('{adr: 12'h142, data: 64'h8000_0000_0000_0005});
        exp_q.push_back('{adr: 12'h143, data: 64'h0});
        exp_q.push_back('{adr: 12'h100, data: 64'h20});
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk); #1;
            if (k == 1) bus.TrapValid = 1'b0;
        end
        @(negedge clk);
        total++;
        if (bus.RedirectValid !== 1'b1 || bus.RedirectPC !== want_pc) begin
            bad++;
            $display("FAIL s_redirect got rv=%b pc=%h want rv=1 pc=%h", bus.RedirectValid, bus.RedirectPC, want_pc);
        end
        @(posedge clk); #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL s_writes_pending got %0d want 0", exp_q.size());
        end
    endtask

    task automatic test_contention();
        @(posedge clk); #1;
        drive_trap(1'b1, 6'h03, 64'h100, 64'h7, 2'b11, 64'h0, 64'h200, 64'h0);
        bus.CSRReqValid = 1'b1;
        bus.CSRReqAdr   = 12'h140;
        bus.CSRReqData  = 64'h55;
        exp_q.push_back('{adr: 12'h341, data: 64'h100});
        exp_q.push_back('{adr: 12'h342, data: 64'h3});
        exp_q.push_back('{adr: 12'h343, data: 64'h7});
        exp_q.push_back('{adr: 12'h300, data: 64'h1800});
        exp_q.push_back('{adr: 12'h140, data: 64'h55});
        @(negedge clk);
        total++;
        if (bus.TrapReady !== 1'b1 || bus.CSRReqReady !== 1'b0 || bus.CSRWrEn !== 1'b0) begin
            bad++;
            $display("FAIL contention_c0 got tr=%b cr=%b en=%b want tr=1 cr=0 en=0",
                     bus.TrapReady, bus.CSRReqReady, bus.CSRWrEn);
        end
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk); #1;
            if (k == 1) bus.TrapValid = 1'b0;
            @(negedge clk);
            total++;
            if (bus.CSRReqReady !== (k == 6)) begin
                bad++;
                $display("FAIL contention_held cycle=%0d got cr=%b want %b", k, bus.CSRReqReady, (k == 6));
            end
        end
        @(posedge clk); #1;
        bus.CSRReqValid = 1'b0;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL contention_pending got %0d want 0", exp_q.size());
        end
    endtask

    task automatic test_pass_through();
        @(posedge clk); #1;
        idle_inputs();
        bus.CSRReqValid = 1'b1;
        bus.CSRReqAdr   = 12'h105;
        bus.CSRReqData  = 64'h1234;
        exp_q.push_back('{adr: 12'h105, data: 64'h1234});
        @(negedge clk);
        total++;
        if (bus.CSRWrEn !== 1'b1 || bus.CSRReqReady !== 1'b1 || bus.BusyStall !== 1'b0) begin
            bad++;
            $display("FAIL pass_through got en=%b cr=%b busy=%b want en=1 cr=1 busy=0",
                     bus.CSRWrEn, bus.CSRReqReady, bus.BusyStall);
        end
        @(posedge clk); #1;
        bus.CSRReqValid = 1'b0;
        @(negedge clk);
        total++;
        if (bus.BusyStall !== 1'b0 || bus.CSRWrEn !== 1'b0 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL pass_after got busy=%b en=%b pending=%0d want 0 0 0",
                     bus.BusyStall, bus.CSRWrEn, exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1;
        drive_trap(1'b0, 6'h01, 64'h300, 64'h9, 2'b01, 64'h2, 64'h0, 64'h700);
        exp_q.push_back('{adr: 12'h141, data: 64'h300});
        exp_q.push_back('{adr: 12'h142, data: 64'h1});
        @(posedge clk); #1;
        bus.TrapValid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        total++;
        if (bus.BusyStall !== 1'b0 || bus.CSRWrEn !== 1'b0 || bus.RedirectValid !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_idle got busy=%b en=%b rv=%b want 0 0 0",
                     bus.BusyStall, bus.CSRWrEn, bus.RedirectValid);
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            total++;
            if (bus.RedirectValid !== 1'b0 || bus.CSRWrEn !== 1'b0) begin
                bad++;
                $display("FAIL reset_mid_quiet got rv=%b en=%b want 0 0", bus.RedirectValid, bus.CSRWrEn);
            end
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL reset_mid_pending got %0d want 0", exp_q.size());
        end
    endtask

    task automatic test_input_change();
        @(posedge clk); #1;
        drive_trap(1'b1, 6'h0B, 64'h2000, 64'h0, 2'b01, 64'hA, 64'h4000_0000, 64'h0);
        exp_q.push_back('{adr: 12'h341, data: 64'h2000});
        exp_q.push_back('{adr: 12'h342, data: 64'hB});
        exp_q.push_back('{adr: 12'h343, data: 64'h0});
        exp_q.push_back('{adr: 12'h300, data: 64'h882});
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk); #1;
            bus.TrapValid      = 1'b0;
            bus.TrapEPC        = 64'hFFFF + k;
            bus.STATUS_REGW    = '0;
            bus.MTVEC_REGW     = 64'h123401;
            bus.TrapCause      = 6'h3F;
            bus.PrivilegeModeW = 2'b11;
        end
        @(negedge clk);
        total++;
        if (bus.RedirectValid !== 1'b1 || bus.RedirectPC !== 64'h4000_0000) begin
            bad++;
            $display("FAIL latch_redirect got rv=%b pc=%h want rv=1 pc=%h",
                     bus.RedirectValid, bus.RedirectPC, 64'h4000_0000);
        end
        @(posedge clk); #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL latch_pending got %0d want 0", exp_q.size());
        end
    endtask

    task automatic test_back_to_back();
        @(posedge clk); #1;
        idle_inputs();
        drive_trap(1'b1, 6'h04, 64'h600, 64'h1, 2'b00, 64'h0, 64'h800, 64'h0);
        for (int n = 0; n < 2; n++) begin
            exp_q.push_back('{adr: 12'h341, data: 64'h600});
            exp_q.push_back('{adr: 12'h342, data: 64'h4});
            exp_q.push_back('{adr: 12'h343, data: 64'h1});
            exp_q.push_back('{adr: 12'h300, data: 64'h0});
        end
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            if (k == 7) bus.TrapValid = 1'b0;
            @(negedge clk);
            if (k <= 6) begin
                total++;
                if (bus.TrapReady !== (k == 6) || bus.BusyStall !== (k != 6)) begin
                    bad++;
                    $display("FAIL b2b_accept cycle=%0d got tr=%b busy=%b want tr=%b busy=%b",
                             k, bus.TrapReady, bus.BusyStall, (k == 6), (k != 6));
                end
            end
        end
        @(posedge clk); #1;
        total++;
        if (exp_q.size() != 0 || bus.BusyStall !== 1'b0) begin
            bad++;
            $display("FAIL b2b_end got pending=%0d busy=%b want 0 0", exp_q.size(), bus.BusyStall);
        end
    endtask

    initial begin
        test_reset();
        test_m_trap();
        test_s_interrupt();
        test_contention();
        test_pass_through();
        test_reset_mid();
        test_input_change();
        test_back_to_back();
        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
